branch_pred_unit: RTL

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/br_cond_eval.sv | 27 ++
 rtl/branch_pred_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch funct3 codes, and the branch
// predictor entry layout with its counter reset/allocate values.
package cpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [1:0] CTR_RESET = 2'd1;
  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam logic [1:0] CTR_JUMP  = 2'd3;
  localparam logic [1:0] CTR_MAX   = 2'd3;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JUMP
  } cf_kind_t;

  // Tag is kept at full width (pc[31:2]) and zero-extended for small indices.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int unsigned idxw);
    return 30'(pc >> (idxw + 2));
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Evaluates a B-type funct3 condition from the comparator results; cond_valid
// is low for the reserved funct3 codes 2 and 3.
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       cond_true,
  output logic       cond_valid
);

  always_comb begin
    cond_true  = 1'b0;
    cond_valid = 1'b1;
    case (funct3)
      F3_BEQ:  cond_true = br_equal;
      F3_BNE:  cond_true = ~br_equal;
      F3_BLT:  cond_true = br_less;
      F3_BGE:  cond_true = ~br_less;
      F3_BLTU: cond_true = br_less;
      F3_BGEU: cond_true = ~br_less;
      default: cond_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped branch predictor with 2-bit counters: fetch-stage lookup,
// execute-stage resolution, table update and saturating perf counters.
module branch_pred_unit
  import cpu_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int CNT_SAT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pcF,
  output logic                 pred_takenF,
  output logic [31:0]          pred_pcF,
  input  logic                 validE,
  input  logic [31:0]          pcE,
  input  logic [31:0]          instrE,
  input  logic                 br_lessE,
  input  logic                 br_equalE,
  input  logic [31:0]          targetE,
  input  logic                 pred_takenE,
  input  logic [31:0]          pred_pcE,
  output logic                 br_selE,
  output logic                 mispredE,
  output logic [31:0]          redirect_pcE,
  output logic [CNT_SAT_W-1:0] br_cntE,
  output logic [CNT_SAT_W-1:0] misp_cntE
);

  localparam int IDXW = $clog2(ENTRIES);

  bp_entry_t bp_table_q [ENTRIES];

  logic [IDXW-1:0] idx_f;
  logic [IDXW-1:0] idx_e;
  bp_entry_t       entry_f;
  bp_entry_t       entry_e;
  logic [29:0]     tag_e;
  logic            hit_f;
  logic            hit_e;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  cf_kind_t        cf_kind;
  logic            cond_true;
  logic            cond_valid;
  logic            is_cf;
  logic            alias_inval;
  logic            wr_en;
  bp_entry_t       wr_entry;
  logic            unused_bits;

  assign unused_bits = ^{pcF[1:0], pcE[1:0], instrE[31:15], instrE[11:7]};

  // Lookup reads registered state only, so a write is seen one cycle later.
  assign idx_f       = pcF[IDXW+1:2];
  assign entry_f     = bp_table_q[idx_f];
  assign hit_f       = entry_f.valid && (entry_f.tag == pc_tag(pcF, IDXW));
  assign pred_takenF = hit_f && entry_f.ctr[1];
  assign pred_pcF    = pred_takenF ? entry_f.target : pcF + 32'd4;

  assign opcode = instrE[6:0];
  assign funct3 = instrE[14:12];

  always_comb begin
    cf_kind = CF_NONE;
    case (opcode)
      OP_BRANCH:        cf_kind = CF_BRANCH;
      OP_JAL, OP_JALR:  cf_kind = CF_JUMP;
      default:          cf_kind = CF_NONE;
    endcase
  end

  br_cond_eval u_cond (
    .funct3     (funct3),
    .br_less    (br_lessE),
    .br_equal   (br_equalE),
    .cond_true  (cond_true),
    .cond_valid (cond_valid)
  );

  assign is_cf   = validE && ((cf_kind == CF_JUMP) || ((cf_kind == CF_BRANCH) && cond_valid));
  assign br_selE = validE && ((cf_kind == CF_JUMP) || ((cf_kind == CF_BRANCH) && cond_true));

  assign redirect_pcE = br_selE ? targetE : pcE + 32'd4;
  assign mispredE     = validE && ((pred_takenE != br_selE) || (br_selE && (pred_pcE != targetE)));

  assign idx_e   = pcE[IDXW+1:2];
  assign entry_e = bp_table_q[idx_e];
  assign tag_e   = pc_tag(pcE, IDXW);
  assign hit_e   = entry_e.valid && (entry_e.tag == tag_e);

  // A predicted-taken non-branch means the entry aliases; drop it.
  assign alias_inval = validE && !is_cf && pred_takenE && hit_e;

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = entry_e;
    if (alias_inval) begin
      wr_en          = 1'b1;
      wr_entry.valid = 1'b0;
    end else if (is_cf) begin
      if (cf_kind == CF_JUMP) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: tag_e, target: targetE, ctr: CTR_JUMP};
      end else if (hit_e) begin
        wr_en = 1'b1;
        if (br_selE) begin
          wr_entry.target = targetE;
          if (entry_e.ctr != CTR_MAX) wr_entry.ctr = entry_e.ctr + 2'd1;
        end else if (entry_e.ctr != 2'd0) begin
          wr_entry.ctr = entry_e.ctr - 2'd1;
        end
      end else if (br_selE) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: tag_e, target: targetE, ctr: CTR_ALLOC};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bp_table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (wr_en) begin
      bp_table_q[idx_e] <= wr_entry;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cntE   <= '0;
      misp_cntE <= '0;
    end else begin
      if (is_cf && (br_cntE != '1)) br_cntE <= br_cntE + CNT_SAT_W'(1);
      if (mispredE && (misp_cntE != '1)) misp_cntE <= misp_cntE + CNT_SAT_W'(1);
    end
  end

endmodule
